irq_pending_controller: RTL and testbench

//   Upstream stage of the 8:3 priority encoder path. Converts raw request lines into

---
 rtl/irq_pending_controller.sv | 93 +++++++++
 tb/tb_irq_pending_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_controller.sv
// rtl/irq_pending_controller.sv - sticky rising-edge pending register with masked MSB-first valid/ready presenter
// Feeds the 8:3 encoder path; a presented index is held until the consumer accepts it.
module irq_pending_controller #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    output logic [IDW-1:0] irq_id,
    output logic           irq_valid,
    input  logic           irq_ready,
    output logic [N-1:0]   pending
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   req_q, req_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [IDW-1:0] irq_id_q, irq_id_d;
    logic           irq_valid_q, irq_valid_d;

    logic [N-1:0]   rise;
    logic [N-1:0]   clr;
    logic [N-1:0]   eligible;
    logic [IDW-1:0] winner;
    logic           accept;

    always_comb begin
        rise     = req & ~req_q;
        eligible = pending_q & mask;
        accept   = (state_q == PRESENT) && irq_ready;

        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i]) winner = IDW'(i);
        end

        clr = '0;
        if (accept) clr[irq_id_q] = 1'b1;

        // rise is OR-ed last so a new edge on the line being cleared keeps it pending
        req_d     = req;
        pending_d = (pending_q & ~clr) | rise;

        state_d     = state_q;
        irq_id_d    = irq_id_q;
        irq_valid_d = irq_valid_q;
        case (state_q)
            IDLE: begin
                irq_valid_d = 1'b0;
                if (|eligible) begin
                    irq_id_d    = winner;
                    irq_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ready) begin
                    irq_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                irq_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            pending_q   <= '0;
            irq_id_q    <= '0;
            irq_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            pending_q   <= pending_d;
            irq_id_q    <= irq_id_d;
            irq_valid_q <= irq_valid_d;
        end
    end

    assign irq_id    = irq_id_q;
    assign irq_valid = irq_valid_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_irq_pending_controller.sv
// tb/tb_irq_pending_controller.sv - scoreboard bench for irq_pending_controller
module tb_irq_pending_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic [2:0] irq_id;
    logic       irq_valid;
    logic       irq_ready;
    logic [7:0] pending;

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    irq_pending_controller #(.N(8), .IDW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .irq_id    (irq_id),
        .irq_valid (irq_valid),
        .irq_ready (irq_ready),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || irq_valid) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || irq_valid) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d_left expected=0_left", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: a transfer is committed at the next posedge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && irq_valid && irq_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_transfer actual=%0d expected=none", irq_id);
            end else begin
                chk("transfer_id", 32'(irq_id), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; mask = 8'hFF; irq_ready = 1'b0;
        tick(); tick();
        chk("reset_valid", 32'(irq_valid), 0);
        chk("reset_id", 32'(irq_id), 0);
        chk("reset_pending", 32'(pending), 0);

        // 1: single line, latency two edges
        rst = 1'b0; irq_ready = 1'b1;
        tick();
        exp_q.push_back(3'd0);
        req = 8'h01;
        tick();
        chk("t1_pending_e0", 32'(pending), 32'h01);
        chk("t1_valid_e0", 32'(irq_valid), 0);
        tick();
        chk("t1_valid_e1", 32'(irq_valid), 1);
        chk("t1_id_e1", 32'(irq_id), 0);
        tick();
        chk("t1_pending_after", 32'(pending), 0);
        chk("t1_valid_after", 32'(irq_valid), 0);
        req = '0;
        tick();

        // 2: two lines rise together, MSB first
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd2);
        req = 8'h44;
        drain("t2");
        chk("t2_pending_end", 32'(pending), 0);
        req = '0;
        tick();

        // 3: all lines, backpressure then ordered service
        irq_ready = 1'b0;
        req = 8'hFF;
        tick(); tick();
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", 32'(irq_valid), 1);
            chk("t3_hold_id", 32'(irq_id), 7);
            tick();
        end
        for (int k = 7; k >= 0; k--) exp_q.push_back(3'(k));
        irq_ready = 1'b1;
        drain("t3");
        chk("t3_pending_end", 32'(pending), 0);
        req = '0;
        tick();

        // 4: masked line latches pending but is not presented until unmasked
        mask = 8'h7F;
        req = 8'h80;
        tick(); tick(); tick();
        chk("t4_masked_valid", 32'(irq_valid), 0);
        chk("t4_masked_pending", 32'(pending), 32'h80);
        exp_q.push_back(3'd7);
        mask = 8'hFF;
        tick();
        chk("t4_unmask_valid", 32'(irq_valid), 1);
        chk("t4_unmask_id", 32'(irq_id), 7);
        drain("t4");
        req = '0;
        tick();

        // 5: new edge on the accept cycle keeps the bit pending
        irq_ready = 1'b0;
        req = 8'h08;
        tick(); tick();
        chk("t5_valid", 32'(irq_valid), 1);
        chk("t5_id", 32'(irq_id), 3);
        req = '0;
        tick();
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd3);
        req = 8'h08;
        irq_ready = 1'b1;
        tick();
        chk("t5_pending_kept", 32'(pending), 32'h08);
        chk("t5_valid_idle", 32'(irq_valid), 0);
        drain("t5");
        chk("t5_pending_end", 32'(pending), 0);
        req = '0;
        tick();

        // 6: reset during a presented transfer, line held high through reset
        irq_ready = 1'b0;
        req = 8'h01;
        tick(); tick();
        chk("t6_pre_valid", 32'(irq_valid), 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_valid", 32'(irq_valid), 0);
        chk("t6_rst_id", 32'(irq_id), 0);
        chk("t6_rst_pending", 32'(pending), 0);
        rst = 1'b0;
        exp_q.push_back(3'd0);
        irq_ready = 1'b1;
        tick();
        chk("t6_pending_e0", 32'(pending), 32'h01);
        chk("t6_valid_e0", 32'(irq_valid), 0);
        tick();
        chk("t6_valid_e1", 32'(irq_valid), 1);
        chk("t6_id_e1", 32'(irq_id), 0);
        drain("t6");
        chk("t6_pending_end", 32'(pending), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
